// File: rtl/sass_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sass_pkg
// Purpose  : Shared widths and reset constants for the PWM audio output path.
// Revision : 1.0 - initial release
// ============================================================================
package sass_pkg;

    localparam int PWM_BITS   = 8;
    localparam int FRAME_LEN  = 256;
    localparam int PRESC_BITS = 16;

    typedef logic [PWM_BITS-1:0] pwm_word_t;

    localparam pwm_word_t DUTY_RESET = 8'h80;
    localparam pwm_word_t CNT_MAX    = pwm_word_t'(FRAME_LEN - 1);
    localparam pwm_word_t SIGN_FLIP  = 8'h80;

endpackage : sass_pkg
`default_nettype wire

// File: rtl/pwm_out_if.sv
`default_nettype none
// ============================================================================
// Module   : pwm_out_if
// Purpose  : Valid/ready sample handshake between waveshaper and PWM output.
// Revision : 1.0 - initial release
// ============================================================================
interface pwm_out_if;
    import sass_pkg::*;

    pwm_word_t sample;
    logic      sample_valid;
    logic      sample_ready;

    modport master (output sample, output sample_valid, input  sample_ready);
    modport slave  (input  sample, input  sample_valid, output sample_ready);

endinterface : pwm_out_if
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Divide-by-DIV prescaler; one-clk tick every DIV clks while enabled.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen
    import sass_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  wire logic clk,
    input  wire logic Rst_i,
    input  wire logic enable_i,
    output logic      tick_o
);

    localparam logic [PRESC_BITS-1:0] LAST = PRESC_BITS'(DIV - 1);

    logic [PRESC_BITS-1:0] presc_q;
    logic [PRESC_BITS-1:0] presc_d;
    logic                  at_last;

    // With DIV=1 LAST is zero, so the counter never leaves 0 and tick follows enable.
    assign at_last = (presc_q == LAST);
    assign tick_o  = enable_i & at_last;

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (!enable_i || at_last) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge Rst_i) begin
        if (!Rst_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : pwm_out
// Purpose  : 8-bit PWM DAC with double-buffered sample, frame strobe, underrun.
//            Build option PWM_SIGNED_EN: treat sample as two's complement.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_out
    import sass_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  wire logic clk,
    input  wire logic Rst_i,
    pwm_out_if.slave  smp_if,
    input  wire logic enable_i,
    input  wire logic underrun_clr_i,
    output logic      pwm_o,
    output logic      frame_o,
    output logic      underrun_o
);

    logic      tick;
    logic      wrap;
    logic      xfer;
    pwm_word_t sample_in;

    pwm_word_t cnt_q,  cnt_d;
    pwm_word_t hold_q, hold_d;
    pwm_word_t duty_q, duty_d;
    logic      hold_full_q, hold_full_d;
    logic      underrun_q,  underrun_d;
    logic      pwm_q,       pwm_d;
    logic      frame_q,     frame_d;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk      (clk),
        .Rst_i    (Rst_i),
        .enable_i (enable_i),
        .tick_o   (tick)
    );

`ifdef PWM_SIGNED_EN
    assign sample_in = smp_if.sample ^ SIGN_FLIP;
`else
    assign sample_in = smp_if.sample;
`endif

    assign smp_if.sample_ready = ~hold_full_q;
    assign xfer                = smp_if.sample_valid & ~hold_full_q;
    assign wrap                = tick & (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        duty_d      = duty_q;
        hold_full_d = hold_full_q;
        underrun_d  = underrun_q;

        if (!enable_i) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Wrap decides on the pre-edge hold_full; a same-cycle transfer refills hold.
        if (wrap && hold_full_q) begin
            duty_d      = hold_q;
            hold_full_d = 1'b0;
        end
        if (xfer) begin
            hold_d      = sample_in;
            hold_full_d = 1'b1;
        end

        if (wrap && !hold_full_q) begin
            underrun_d = 1'b1;
        end else if (underrun_clr_i) begin
            underrun_d = 1'b0;
        end

        pwm_d   = enable_i & (cnt_q < duty_q);
        frame_d = wrap;
    end

    always_ff @(posedge clk or negedge Rst_i) begin
        if (!Rst_i) begin
            cnt_q       <= '0;
            hold_q      <= '0;
            duty_q      <= DUTY_RESET;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
            pwm_q       <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            duty_q      <= duty_d;
            hold_full_q <= hold_full_d;
            underrun_q  <= underrun_d;
            pwm_q       <= pwm_d;
            frame_q     <= frame_d;
        end
    end

    assign pwm_o      = pwm_q;
    assign frame_o    = frame_q;
    assign underrun_o = underrun_q;

endmodule : pwm_out
`default_nettype wire

// File: tb/tb_pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_out
// Purpose  : Directed self-checking bench for pwm_out (DIV=1 and DIV=4 copies).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_out;

    typedef struct {
        logic [7:0] sample;
        int         exp_u;
        int         exp_s;
    } vec_t;

`ifdef PWM_SIGNED_EN
    localparam int DUTY_200 = 72;
    localparam int DUTY_64  = 192;
`else
    localparam int DUTY_200 = 200;
    localparam int DUTY_64  = 64;
`endif

    logic clk = 1'b0;
    logic Rst_i;
    logic en1, en4, clr1, clr4;
    logic pwm1, frame1, ur1;
    logic pwm4, frame4, ur4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pwm_out_if if1 ();
    pwm_out_if if4 ();

    pwm_out #(.DIV(1)) u_dut1 (
        .clk            (clk),
        .Rst_i          (Rst_i),
        .smp_if         (if1.slave),
        .enable_i       (en1),
        .underrun_clr_i (clr1),
        .pwm_o          (pwm1),
        .frame_o        (frame1),
        .underrun_o     (ur1)
    );

    pwm_out #(.DIV(4)) u_dut4 (
        .clk            (clk),
        .Rst_i          (Rst_i),
        .smp_if         (if4.slave),
        .enable_i       (en4),
        .underrun_clr_i (clr4),
        .pwm_o          (pwm4),
        .frame_o        (frame4),
        .underrun_o     (ur4)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int exp_of(input vec_t v);
`ifdef PWM_SIGNED_EN
        return v.exp_s;
`else
        return v.exp_u;
`endif
    endfunction

    function automatic logic rdy(input bit sel);
        return sel ? if4.sample_ready : if1.sample_ready;
    endfunction

    task automatic send(input bit sel, input logic [7:0] s, input string name);
        int waited = 0;
        while (!rdy(sel) && waited < 4000) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_ready_before"}, int'(rdy(sel)), 1);
        if (sel) begin if4.sample = s; if4.sample_valid = 1'b1; end
        else     begin if1.sample = s; if1.sample_valid = 1'b1; end
        @(negedge clk);
        if1.sample_valid = 1'b0;
        if4.sample_valid = 1'b0;
        check({name, "_ready_drop"}, int'(rdy(sel)), 0);
    endtask

    task automatic wait_frame(input bit sel, input string name);
        int   i    = 0;
        logic seen = 1'b0;
        while (!seen && i < 4000) begin
            @(negedge clk);
            seen = sel ? frame4 : frame1;
            i++;
        end
        check({name, "_frame_seen"}, int'(seen), 1);
    endtask

    // Counts pwm highs over one frame window; the frame strobe must land on the last sample only.
    task automatic measure(input bit sel, input int len, input int exp_high, input string name);
        int highs = 0;
        int early = 0;
        int fend  = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            highs += int'(sel ? pwm4 : pwm1);
            if (i < len - 1) early += int'(sel ? frame4 : frame1);
            else             fend   = int'(sel ? frame4 : frame1);
        end
        check({name, "_high"},       highs, exp_high);
        check({name, "_frame_early"}, early, 0);
        check({name, "_frame_end"},   fend,  1);
    endtask

    task automatic pulse_clr(input bit sel, input string name);
        if (sel) clr4 = 1'b1; else clr1 = 1'b1;
        @(negedge clk);
        clr1 = 1'b0;
        clr4 = 1'b0;
        check({name, "_ur_clr"}, int'(sel ? ur4 : ur1), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   cnt_f;
        int   cnt_h;

        vecs[0] = '{sample: 8'd127, exp_u: 127, exp_s: 255};
        vecs[1] = '{sample: 8'd0,   exp_u: 0,   exp_s: 128};
        vecs[2] = '{sample: 8'd255, exp_u: 255, exp_s: 127};
        vecs[3] = '{sample: 8'h81,  exp_u: 129, exp_s: 1};
        vecs[4] = '{sample: 8'h01,  exp_u: 1,   exp_s: 129};

        Rst_i = 1'b0;
        en1 = 1'b0; en4 = 1'b0; clr1 = 1'b0; clr4 = 1'b0;
        if1.sample = '0; if1.sample_valid = 1'b0;
        if4.sample = '0; if4.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pwm",   int'(pwm1),  0);
        check("rst_frame", int'(frame1), 0);
        check("rst_ur",    int'(ur1),   0);
        check("rst_ready", int'(if1.sample_ready), 1);
        Rst_i = 1'b1;
        @(negedge clk);

        // First frame runs at the reset duty with no sample queued.
        en1 = 1'b1;
        measure(1'b0, 256, 128, "first_frame");
        check("first_wrap_ur", int'(ur1), 1);

        for (int i = 0; i < 5; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            pulse_clr(1'b0, nm);
            send(1'b0, vecs[i].sample, nm);
            wait_frame(1'b0, nm);
            check({nm, "_ready_back"}, int'(if1.sample_ready), 1);
            check({nm, "_ur_loaded"},  int'(ur1), 0);
            measure(1'b0, 256, exp_of(vecs[i]), nm);
        end

        // Sample offered exactly on the wrap cycle while hold is empty.
        pulse_clr(1'b0, "wrapv");
        repeat (254) @(negedge clk);
        if1.sample = 8'd200; if1.sample_valid = 1'b1;
        @(negedge clk);
        if1.sample_valid = 1'b0;
        check("wrapv_ur",    int'(ur1),    1);
        check("wrapv_frame", int'(frame1), 1);
        check("wrapv_ready", int'(if1.sample_ready), 0);
        measure(1'b0, 256, exp_of(vecs[4]), "wrapv_same_duty");
        check("wrapv_ur_sticky", int'(ur1), 1);
        pulse_clr(1'b0, "dis");
        repeat (9) @(negedge clk);
        check("dis_pwm_before", int'(pwm1), 1);

        // Drop enable mid-frame, then restart from cnt=0 with the held duty.
        en1 = 1'b0;
        @(negedge clk);
        check("dis_pwm_now", int'(pwm1), 0);
        cnt_f = 0; cnt_h = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            cnt_f += int'(frame1);
            cnt_h += int'(pwm1);
        end
        check("dis_no_frame", cnt_f, 0);
        check("dis_no_pwm",   cnt_h, 0);
        en1 = 1'b1;
        measure(1'b0, 256, DUTY_200, "reen");

        // Asynchronous reset mid-frame, away from any clock edge.
        @(posedge clk);
        #2;
        check("pre_rst_pwm", int'(pwm1), 1);
        check("pre_rst_ur",  int'(ur1),  1);
        Rst_i = 1'b0;
        #1;
        check("arst_pwm",   int'(pwm1),  0);
        check("arst_frame", int'(frame1), 0);
        check("arst_ur",    int'(ur1),   0);
        check("arst_ready", int'(if1.sample_ready), 1);
        @(negedge clk);
        Rst_i = 1'b1;
        measure(1'b0, 256, 128, "post_rst");

        // DIV=4: handshake while idle, then 1024-clk frames.
        send(1'b1, 8'd64, "d4");
        en4 = 1'b1;
        measure(1'b1, 1024, 512, "d4_first");
        check("d4_ur", int'(ur4), 0);
        measure(1'b1, 1024, 4 * DUTY_64, "d4_s64");
        repeat (20) @(negedge clk);
        check("d4_pwm_before", int'(pwm4), 1);
        en4 = 1'b0;
        @(negedge clk);
        check("d4_dis_pwm", int'(pwm4), 0);
        repeat (5) @(negedge clk);
        en4 = 1'b1;
        measure(1'b1, 1024, 4 * DUTY_64, "d4_reen");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_pwm_out
`default_nettype wire
